// File: rtl/fib_19_unwind.sv
// fib_19_unwind: runs the two-phase counter loop backwards from a loaded end state to (0, Y_INIT)
// Ports: clk, rst (async active-low); start/x_in/y_in load request (taken in IDLE only);
// step_en advances one reverse step; busy while unwinding; done one-cycle pulse on finish or reject;
// err sticky reject flag; x/y current state; inv_ok combinational loop-invariant check.
module fib_19_unwind #(
    parameter int W      = 11,
    parameter int X_MAX  = 200,
    parameter int X_KNEE = 100,
    parameter int Y_INIT = 100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic         step_en,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         inv_ok
);
    localparam logic [W-1:0] XM  = W'(X_MAX);
    localparam logic [W-1:0] XK  = W'(X_KNEE);
    localparam logic [W-1:0] YI  = W'(Y_INIT);
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;
    state_t state;

    // y implied by the invariant for a given x; only meaningful for x <= X_MAX
    function automatic logic [W-1:0] y_of(input logic [W-1:0] v);
        return v > XK ? YI + (v - XK) : YI;
    endfunction

    logic legal;
    assign legal  = x_in <= XM && y_in == y_of(x_in);
    assign inv_ok = x <= XM && y == y_of(x);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            x     <= '0;
            y     <= YI;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (legal) begin
                        x   <= x_in;
                        y   <= y_in;
                        err <= 1'b0;
                        if (x_in == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= x_in > XK ? HI : LO;
                        end
                    end else begin
                        err  <= 1'b1;
                        done <= 1'b1;
                    end
                end
                HI: if (step_en) begin
                    x <= x - ONE;
                    y <= y - ONE;
                    if (x - ONE == XK) state <= LO;
                end
                LO: if (step_en) begin
                    x <= x - ONE;
                    if (x == ONE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_19_unwind.sv
// tb_fib_19_unwind: directed plus random stimulus against an abstract reverse-loop model
module tb_fib_19_unwind;
    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         step_en = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic         busy, done, err, inv_ok;
    logic [W-1:0] x, y;

    fib_19_unwind #(.W(W), .X_MAX(200), .X_KNEE(100), .Y_INIT(100)) dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in), .step_en(step_en),
        .busy(busy), .done(done), .err(err), .x(x), .y(y), .inv_ok(inv_ok)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ex = 0, ebusy = 0, edone = 0, eerr = 0;
    int dones = 0;

    // the loop's invariant: y is Y_INIT plus however far x sits above the knee
    function automatic int ey(input int v);
        return 100 + (v > 100 ? v - 100 : 0);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare();
        chk("x", int'(x), ex);
        chk("y", int'(y), ey(ex));
        chk("busy", int'(busy), ebusy);
        chk("done", int'(done), edone);
        chk("err", int'(err), eerr);
        chk("inv_ok", int'(inv_ok), 1);
    endtask

    task automatic model_step();
        int xv, yv;
        xv = int'(x_in);
        yv = int'(y_in);
        edone = 0;
        if (ebusy == 0) begin
            if (start) begin
                if (xv <= 200 && yv == ey(xv)) begin
                    ex = xv;
                    eerr = 0;
                    if (xv == 0) edone = 1;
                    else ebusy = 1;
                end else begin
                    eerr = 1;
                    edone = 1;
                end
            end
        end else if (step_en) begin
            ex--;
            if (ex == 0) begin
                ebusy = 0;
                edone = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        compare();
        dones += int'(done);
    endtask

    task automatic load(input int xv, input int yv);
        start = 1'b1;
        x_in = W'(xv);
        y_in = W'(yv);
        tick();
        start = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        compare();
        rst = 1'b1;

        step_en = 1'b1;
        dones = 0;
        load(200, 200);
        chk("s1_busy_edge1", int'(busy), 1);
        repeat (205) tick();
        chk("s1_done_count", dones, 1);

        dones = 0;
        load(150, 150);
        for (int i = 0; i < 300; i++) begin
            step_en = i[0];
            tick();
        end
        step_en = 1'b1;
        chk("s2_done_count", dones, 1);
        chk("s2_x_final", int'(x), 0);

        dones = 0;
        load(201, 201);
        chk("s3_err_a", int'(err), 1);
        tick();
        load(120, 100);
        chk("s3_err_b", int'(err), 1);
        chk("s3_busy", int'(busy), 0);
        load(50, 100);
        chk("s3_err_clr", int'(err), 0);
        repeat (60) tick();

        dones = 0;
        load(0, 100);
        chk("s4_zero_done", int'(done), 1);
        chk("s4_zero_busy", int'(busy), 0);
        tick();
        load(100, 100);
        repeat (105) tick();
        load(101, 101);
        repeat (105) tick();
        chk("s4_done_count", dones, 3);

        load(200, 200);
        for (int i = 0; i < 300 && ex != 60; i++) tick();
        chk("s5_reach60", int'(x), 60);
        start = 1'b1;
        x_in = W'(10);
        y_in = W'(100);
        tick();
        start = 1'b0;
        chk("s5_ignored", int'(x), 59);
        for (int i = 0; i < 300 && ex != 40; i++) tick();
        #2 rst = 1'b0;
        #1;
        ex = 0; ebusy = 0; edone = 0; eerr = 0;
        compare();
        tick();
        tick();
        #2 rst = 1'b1;
        dones = 0;
        repeat (10) tick();
        chk("s5_no_done", dones, 0);

        for (int i = 0; i < 8000; i++) begin
            int xv;
            xv = $urandom_range(0, 210);
            start = ($urandom % 6) == 0;
            x_in = W'(xv);
            y_in = ($urandom % 2) ? W'(ey(xv)) : W'($urandom_range(90, 215));
            step_en = ($urandom % 4) != 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
